// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: owns the register-file write port. It merges ALU results
// (strict priority) with memory results buffered in a small FIFO, and keeps a
// pending-write scoreboard.
// Optional feature macro: REGFILE_WB_FWD_EN adds combinational write-to-read
// forwarding ports.
module regfile_wb_ctrl #(
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_wb_valid,
    input  logic [ADDR_W-1:0]        alu_wb_dest,
    input  logic [DATA_W-1:0]        alu_wb_data,
    input  logic                     mem_wb_valid,
    output logic                     mem_wb_ready,
    input  logic [ADDR_W-1:0]        mem_wb_dest,
    input  logic [DATA_W-1:0]        mem_wb_data,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_dest,
    output logic [(1<<ADDR_W)-1:0]   pend_mask,
    output logic                     rf_write_en,
    output logic [ADDR_W-1:0]        rf_write_dest,
    output logic [DATA_W-1:0]        rf_write_data
`ifdef REGFILE_WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0]        rd_addr_1,
    input  logic [ADDR_W-1:0]        rd_addr_2,
    input  logic [DATA_W-1:0]        rf_read_data_1,
    input  logic [DATA_W-1:0]        rf_read_data_2,
    output logic [DATA_W-1:0]        fwd_data_1,
    output logic [DATA_W-1:0]        fwd_data_2
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned NREG  = 1 << ADDR_W;

    logic [ADDR_W-1:0] fifo_dest_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [NREG-1:0]   pend_q, pend_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_dest_q, wr_dest_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              push_c;
    logic              pop_c;
    logic              clr_c;
    logic [ADDR_W-1:0] clr_dest_c;

    // Ready depends only on the registered occupancy, never on a same-cycle pop.
    assign mem_wb_ready = !rst && (count_q < CNT_W'(FIFO_DEPTH));

    // Source selection, FIFO bookkeeping and scoreboard next state.
    always_comb begin
        push_c     = mem_wb_valid && mem_wb_ready;
        pop_c      = 1'b0;
        clr_c      = 1'b0;
        clr_dest_c = '0;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        wr_en_d    = 1'b0;
        wr_dest_d  = wr_dest_q;
        wr_data_d  = wr_data_q;
        pend_d     = pend_q;

        if (alu_wb_valid) begin
            clr_c      = 1'b1;
            clr_dest_c = alu_wb_dest;
            wr_en_d    = (alu_wb_dest != '0);
            wr_dest_d  = alu_wb_dest;
            wr_data_d  = alu_wb_data;
        end else if (count_q != '0) begin
            pop_c      = 1'b1;
            clr_c      = 1'b1;
            clr_dest_c = fifo_dest_q[head_q];
            wr_en_d    = (fifo_dest_q[head_q] != '0);
            wr_dest_d  = fifo_dest_q[head_q];
            wr_data_d  = fifo_data_q[head_q];
        end

        if (pop_c) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push_c) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CNT_W'(1);
        end

        // Clear first so a same-cycle issue to the same register wins.
        if (clr_c) begin
            pend_d[clr_dest_c] = 1'b0;
        end
        if (iss_valid && (iss_dest != '0)) begin
            pend_d[iss_dest] = 1'b1;
        end
    end

    // Control and output registers; reset discards any buffered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            pend_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_dest_q <= '0;
            wr_data_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            pend_q    <= pend_d;
            wr_en_q   <= wr_en_d;
            wr_dest_q <= wr_dest_d;
            wr_data_q <= wr_data_d;
        end
    end

    // FIFO storage; contents are only meaningful under count_q.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_dest_q[tail_q] <= mem_wb_dest;
            fifo_data_q[tail_q] <= mem_wb_data;
        end
    end

    assign pend_mask     = pend_q;
    assign rf_write_en   = wr_en_q;
    assign rf_write_dest = wr_dest_q;
    assign rf_write_data = wr_data_q;

`ifdef REGFILE_WB_FWD_EN
    // Bypass the in-flight write to readers of the same (non-zero) register.
    assign fwd_data_1 = (wr_en_q && (wr_dest_q == rd_addr_1) && (rd_addr_1 != '0))
                        ? wr_data_q : rf_read_data_1;
    assign fwd_data_2 = (wr_en_q && (wr_dest_q == rd_addr_2) && (rd_addr_2 != '0))
                        ? wr_data_q : rf_read_data_2;
`endif

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller that owns the single write port of the 16 x 24-bit register file. It merges single-cycle ALU results with variable-latency memory (load) results, buffering memory results in a small FIFO and emitting at most one registered write per cycle. It also keeps a pending-write scoreboard for the hazard/stall logic. It sits between the execute/memory stages and the register file.

## Interface
- DATA_W, 24, register data width
- ADDR_W, 4, register address width (2**ADDR_W registers)
- FIFO_DEPTH, 4, memory-result FIFO entries (power of two, >= 2)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- alu_wb_valid  in  1  ALU result present this cycle (no backpressure)
- alu_wb_dest  in  ADDR_W  ALU destination register
- alu_wb_data  in  DATA_W  ALU result
- mem_wb_valid  in  1  memory result offered
- mem_wb_ready  out  1  memory result accepted when valid && ready at posedge
- mem_wb_dest  in  ADDR_W  memory destination register
- mem_wb_data  in  DATA_W  memory result
- iss_valid  in  1  instruction issued that will write iss_dest
- iss_dest  in  ADDR_W  destination of issued instruction
- pend_mask  out  2**ADDR_W  bit i = write to register i outstanding
- rf_write_en  out  1  to register file write enable (registered)
- rf_write_dest  out  ADDR_W  to register file write address (registered)
- rf_write_data  out  DATA_W  to register file write data (registered)

## Operation
- Each cycle, select one source for the output register: ALU if alu_wb_valid, else the FIFO head if the FIFO is non-empty, else nothing (rf_write_en <= 0).
- ALU has strict priority; the FIFO only drains on cycles with no ALU result.
- FIFO pushes when mem_wb_valid && mem_wb_ready. mem_wb_ready = !rst && (count < FIFO_DEPTH), computed from the registered count only. When full, there is no push, even if a pop occurs in the same cycle.
- Simultaneous push and pop: count is unchanged; head and tail pointers both advance and wrap modulo FIFO_DEPTH.
- Writes to dest 0 are dropped. If the ALU targets r0, it still wins the cycle, but rf_write_en <= 0. A FIFO head targeting r0 is popped with rf_write_en <= 0.
- Scoreboard:
  - iss_valid sets pend_mask[iss_dest] (r0 never set).
  - Loading the output register with a write to dest d clears pend_mask[d]; this applies to both enabled writes and dropped r0 writes.
  - Set and clear of the same bit in the same cycle: set wins.
  - Upstream guarantees at most one outstanding write per register by stalling on pend_mask.
- Reset mid-operation: FIFO contents are discarded (pointers and count go to 0), all outputs go to their reset values immediately, and buffered results are lost.

## Timing
- Reset values:
  - rf_write_en = 0, rf_write_dest = 0, rf_write_data = 0
  - pend_mask = 0
  - mem_wb_ready = 0 while rst is high, 1 in the first cycle after rst falls
- ALU latency: result present in cycle N gives rf_write_* valid in cycle N+1; the register file updates at the end of N+1.
- Memory latency: accepted at edge T, then rf_write_* valid in cycle T+1 at the earliest (FIFO empty, no ALU in cycle T). Each intervening ALU cycle adds one cycle.
- FIFO order is strictly preserved; throughput is 1 write/cycle total.
- pend_mask is registered: it changes one edge after iss_valid or after the write selection.

## Configuration
- REGFILE_WB_FWD_EN defined: adds ports rd_addr_1/rd_addr_2 (in, ADDR_W), rf_read_data_1/rf_read_data_2 (in, DATA_W, from the register file) and fwd_data_1/fwd_data_2 (out, DATA_W).
  - fwd_data_k = rf_write_data when rf_write_en && rf_write_dest == rd_addr_k && rd_addr_k != 0.
  - Otherwise fwd_data_k = rf_read_data_k.
  - The forwarding logic is purely combinational.
- Not defined: these ports and the forwarding logic do not exist; consumers read the register file directly and see a write one cycle later.

## Test plan
- ALU only: alu (dest 3, 0x00ABCD) in cycle 1 -> cycle 2 has rf_write_en=1, dest 3, data 0x00ABCD; cycle 3 has rf_write_en=0.
- Priority: same cycle alu (dest 5, 0x111111) and mem (dest 6, 0x222222) accepted -> cycle+1 writes r5, cycle+2 writes r6.
- FIFO full: ALU valid continuously, push 5 memory results -> ready drops after 4 accepted. Release ALU -> 4 writes follow in order, ready returns 1 the cycle after the first pop.
- r0: mem dest 0 data 0xFFFFFF -> popped, rf_write_en stays 0, pend_mask stays 0.
- Scoreboard: iss dest 7 -> pend_mask=0x0080 next cycle. Later mem write r7 -> bit clears at the edge loading the output register. iss dest 7 in that same cycle -> bit stays 1.
- Reset: assert rst with 3 FIFO entries and rf_write_en=1 -> all outputs 0 and mem_wb_ready=0 immediately. After release, no stale writes and mem_wb_ready=1.
